// File: rtl/bcd_countdown_pkg.sv
// Shared types and BCD helpers for the three-digit countdown timer.
// Auto-reload behaviour is selected with BCD_COUNTDOWN_AUTO_RELOAD_EN.
package bcd_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    typedef logic [3:0]  bcd_t;
    typedef logic [11:0] bcd3_t;

    function automatic bcd_t bcd_sat(input bcd_t d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Borrow ripples ones -> tens -> hundreds; 000 wraps to 999.
    function automatic bcd3_t bcd_dec3(input bcd3_t v);
        bcd_t h;
        bcd_t t;
        bcd_t o;
        h = v[11:8];
        t = v[7:4];
        o = v[3:0];
        if (o != 4'd0) begin
            o = o - 4'd1;
        end else begin
            o = 4'd9;
            if (t != 4'd0) begin
                t = t - 4'd1;
            end else begin
                t = 4'd9;
                h = (h != 4'd0) ? h - 4'd1 : 4'd9;
            end
        end
        return {h, t, o};
    endfunction

endpackage

// File: rtl/bcd_countdown_tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while enabled, ticks on the last count.
// Synchronous clear has priority over enable.
module bcd_countdown_tick_gen #(
    parameter int PRESCALE = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = $clog2(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == LAST);
    assign o_tick = i_en & w_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Three-digit BCD countdown timer with prescaler and expiry flag.
// Define BCD_COUNTDOWN_AUTO_RELOAD_EN for pulsed Done and automatic reload.
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [11:0] i_load_value,
    input  logic        i_start,
    input  logic        i_pause,
    output logic [11:0] o_q,
    output logic        o_running,
    output logic        o_done
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;

    state_t r_state;
    bcd3_t  r_q;
    bcd3_t  r_reload;
    logic   r_running;
    logic   r_done;

    bcd3_t  w_sat;
    bcd3_t  w_dec;
    logic   w_start_ok;
    logic   w_q_zero;
    logic   w_clr;
    logic   w_en;
    logic   w_tick;
    logic   w_expire;

    assign w_sat = {bcd_sat(i_load_value[11:8]),
                    bcd_sat(i_load_value[7:4]),
                    bcd_sat(i_load_value[3:0])};
    assign w_dec      = bcd_dec3(r_q);
    assign w_start_ok = i_start & ~i_pause;
    assign w_q_zero   = (r_q == '0);

    assign w_clr = i_load |
                   ((r_state == IDLE) & w_start_ok & ~w_q_zero);
    // A Load on a tick edge discards that tick.
    assign w_en  = (r_state == RUN) & ~i_load;

    assign w_expire = w_tick & ~w_q_zero & (w_dec == '0);

    bcd_countdown_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .i_clk  (i_clock),
        .i_rst  (i_reset),
        .i_en   (w_en),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_reload  <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else if (i_load) begin
            r_state   <= IDLE;
            r_q       <= w_sat;
            r_reload  <= w_sat;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            r_done <= 1'b0;
`endif
            unique case (r_state)
                IDLE: begin
                    if (w_start_ok && !w_q_zero) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    // 000 is shown for a full tick period before reload.
                    if (w_tick) begin
                        r_q <= w_q_zero ? r_reload : w_dec;
                    end
                    if (w_expire) begin
                        r_done <= 1'b1;
                    end
                    if (i_pause) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end
`else
                    if (w_tick) begin
                        r_q <= w_dec;
                    end
                    if (w_expire) begin
                        r_state   <= DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (i_pause) begin
                        r_state   <= PAUSED;
                        r_running <= 1'b0;
                    end
`endif
                end
                PAUSED: begin
                    if (w_start_ok) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

    assign o_q       = r_q;
    assign o_running = r_running;
    assign o_done    = r_done;

endmodule

// File: tb/tb_bcd_countdown.sv
// Self-checking bench for bcd_countdown (PRESCALE = 10).
// Honours BCD_COUNTDOWN_AUTO_RELOAD_EN in its reference model.
module tb_bcd_countdown;

    localparam int P = 10;

    logic        clk;
    logic        rst;
    logic        ld;
    logic [11:0] lv;
    logic        st;
    logic        pa;
    logic [11:0] q;
    logic        running;
    logic        done;

    int n_tests;
    int n_fail;

    // Reference model: decimal value, elapsed cycles in the current tick period
    int m_st;
    int m_val;
    int m_rel;
    int m_ph;
    bit m_run;
    bit m_done;

    bcd_countdown #(
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_load       (ld),
        .i_load_value (lv),
        .i_start      (st),
        .i_pause      (pa),
        .o_q          (q),
        .o_running    (running),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dig(input logic [11:0] v, input int k);
        int d;
        d = int'((v >> (4 * k)) & 12'hF);
        return (d > 9) ? 9 : d;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic model_reset();
        m_st   = 0;
        m_val  = 0;
        m_rel  = 0;
        m_ph   = 0;
        m_run  = 0;
        m_done = 0;
    endtask

    task automatic model_edge(input bit l, input logic [11:0] v,
                              input bit s, input bit p);
        bit tick;
        bit exp_now;
        if (l) begin
            m_val  = dig(v, 2) * 100 + dig(v, 1) * 10 + dig(v, 0);
            m_rel  = m_val;
            m_st   = 0;
            m_ph   = 0;
            m_done = 0;
        end else begin
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            m_done = 0;
`endif
            case (m_st)
                0: if (s && !p && m_val != 0) begin
                    m_st = 1;
                    m_ph = 0;
                end
                1: begin
                    tick    = (m_ph == P - 1);
                    m_ph    = tick ? 0 : m_ph + 1;
                    exp_now = 0;
                    if (tick) begin
                        if (m_val == 0) begin
                            m_val = m_rel;
                        end else begin
                            m_val = m_val - 1;
                            exp_now = (m_val == 0);
                        end
                    end
                    if (exp_now) m_done = 1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    if (p) m_st = 2;
`else
                    if (exp_now) m_st = 3;
                    else if (p) m_st = 2;
`endif
                end
                2: if (s && !p) m_st = 1;
                default: ;
            endcase
        end
        m_run = (m_st == 1);
    endtask

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".q"}, q, to_bcd(m_val));
        chk({tag, ".run"}, 12'(running), 12'(m_run));
        chk({tag, ".done"}, 12'(done), 12'(m_done));
    endtask

    task automatic step(input bit l, input logic [11:0] v,
                        input bit s, input bit p, input string tag);
        ld = l;
        lv = v;
        st = s;
        pa = p;
        @(posedge clk);
        model_edge(l, v, s, p);
        #1;
        chk_model(tag);
        ld = 1'b0;
        st = 1'b0;
        pa = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 12'h000, 0, 0, tag);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        ld  = 1'b0;
        lv  = 12'h000;
        st  = 1'b0;
        pa  = 1'b0;
        model_reset();
        #2;
        chk_model("reset");
        chk("reset.q0", q, 12'h000);
        rst = 1'b0;

`ifndef BCD_COUNTDOWN_AUTO_RELOAD_EN
        // Load 003 and count to expiry
        step(1, 12'h003, 0, 0, "t1.load");
        step(0, 12'h000, 1, 0, "t1.start");
        chk("t1.run_hi", 12'(running), 12'h001);
        idle(9, "t1.wait");
        chk("t1.q_pre", q, 12'h003);
        idle(1, "t1.e10");
        chk("t1.q_e10", q, 12'h002);
        idle(10, "t1.e20");
        chk("t1.q_e20", q, 12'h001);
        idle(10, "t1.e30");
        chk("t1.q_e30", q, 12'h000);
        chk("t1.done", 12'(done), 12'h001);
        chk("t1.run_lo", 12'(running), 12'h000);
        step(0, 12'h000, 1, 0, "t1.start_in_done");
        idle(12, "t1.hold");
        chk("t1.done_hold", 12'(done), 12'h001);
`endif

        // Borrow across digits, then a saturating load
        step(1, 12'h100, 0, 0, "t2.load");
        step(0, 12'h000, 1, 0, "t2.start");
        idle(10, "t2.tick");
        chk("t2.q099", q, 12'h099);
        step(1, 12'hFA0, 0, 0, "t2.sat");
        chk("t2.q990", q, 12'h990);
        chk("t2.idle", 12'(running), 12'h000);

        // Pause at cycle 4 for 50 cycles, then resume
        step(1, 12'h005, 0, 0, "t3.load");
        step(0, 12'h000, 1, 0, "t3.start");
        idle(3, "t3.run");
        for (int i = 0; i < 50; i++) step(0, 12'h000, 0, 1, "t3.pause");
        chk("t3.paused", 12'(running), 12'h000);
        chk("t3.q_held", q, 12'h005);
        step(0, 12'h000, 1, 0, "t3.resume");
        idle(5, "t3.r5");
        chk("t3.q_r5", q, 12'h005);
        idle(1, "t3.r6");
        chk("t3.q_r6", q, 12'h004);
        step(0, 12'h000, 1, 1, "t3.both");
        chk("t3.both_paused", 12'(running), 12'h000);
        step(0, 12'h000, 1, 0, "t3.resume2");
        chk("t3.resumed", 12'(running), 12'h001);

        // Start with zero count is ignored
        step(1, 12'h000, 0, 0, "t4.load");
        step(0, 12'h000, 1, 0, "t4.start");
        idle(3, "t4.wait");
        chk("t4.run_lo", 12'(running), 12'h000);
        chk("t4.q0", q, 12'h000);

        // Asynchronous reset mid-count
        step(1, 12'h042, 0, 0, "t5.load");
        step(0, 12'h000, 1, 0, "t5.start");
        idle(5, "t5.run");
        chk("t5.q042", q, 12'h042);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk_model("t5.async");
        chk("t5.q_rst", q, 12'h000);
        #2;
        rst = 1'b0;
        step(0, 12'h000, 1, 0, "t5.start_noload");
        idle(4, "t5.stay");

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        step(1, 12'h002, 0, 0, "t6.load");
        step(0, 12'h000, 1, 0, "t6.start");
        idle(10, "t6.e10");
        chk("t6.q001", q, 12'h001);
        idle(10, "t6.e20");
        chk("t6.q000", q, 12'h000);
        chk("t6.pulse", 12'(done), 12'h001);
        chk("t6.run20", 12'(running), 12'h001);
        idle(1, "t6.e21");
        chk("t6.pulse_end", 12'(done), 12'h000);
        idle(9, "t6.e30");
        chk("t6.q002", q, 12'h002);
        chk("t6.run30", 12'(running), 12'h001);
`endif

        // Randomised traffic against the model
        for (int it = 0; it < 15; it++) begin
            logic [11:0] v;
            v = 12'($urandom);
            if (it % 2 == 0) v = {4'h0, 4'($urandom_range(0, 2)), 4'($urandom)};
            step(1, v, 0, 0, "rnd.load");
            step(0, 12'h000, 1, 0, "rnd.start");
            for (int c = 0; c < 120; c++) begin
                int r;
                r = int'($urandom_range(0, 99));
                step(r == 99, 12'($urandom), r < 8, r >= 8 && r < 12, "rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
